factorial_ctrl: RTL and testbench
=================================

Name: factorial_ctrl

Overview:
- Control unit that sequences the factorial datapath (accumulator A, down-counter B, zero flag) to compute N!.
- Accepts a start request with an operand.
- Drives the datapath A/B write-select codes each cycle, then holds the result with a valid/ready handshake.
- Rejects operands whose factorial overflows the 2w-bit accumulator; a watchdog aborts if the datapath zero flag never asserts.

Parameters:
- W, 8, operand width; the accumulator/result width is 2*W.
- P_NMAX, 8, largest accepted operand. Default 8 because 8! = 40320 fits 16 bits.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_n  in  W  operand N; sampled together with i_start.
- i_ready  in  1  consumer accepts the result.
- o_busy  out  1  high in every state except IDLE.
- o_valid  out  1  result/err valid; held until i_ready.
- o_result  out  2W  registered N!; 0 on error.
- o_err  out  1  operand out of range, or watchdog abort.
- o_iter  out  W  multiply steps issued in the current operation.
- o_n  out  W  latched operand, drives datapath N input.
- o_wa  out  2  datapath A select: 00 hold, 01 A<=A*B, 10 A<=1.
- o_wb  out  2  datapath B select: 00 B<=N, 01 B<=B-1, 10 hold.
- i_z  in  1  datapath flag, B==0.
- i_a  in  2W  datapath accumulator.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; o_result=0, o_err=0, o_valid=0, o_iter=0, o_n=0.
  - o_wa=00, o_wb=10, so the datapath holds.
  - Reset mid-operation aborts immediately; no o_valid is produced.
- States: IDLE, LOAD, RUN, DONE. Encoding comes from the package; all outputs are registered or decoded from state only.
- IDLE:
  - Drives wa=00, wb=10.
  - On i_start=1 and i_n<=P_NMAX: latch o_n=i_n, clear o_iter and o_err, go to LOAD.
  - On i_start=1 and i_n>P_NMAX: o_result=0, o_err=1, go to DONE (o_valid high one cycle after the start edge).
- LOAD: one cycle, drives wa=10, wb=00 (A<=1, B<=N), then goes to RUN.
- RUN:
  - If i_z=0: drive wa=01, wb=01. A<=A*B and B<=B-1 in the same edge, both using the old B. o_iter increments.
  - If i_z=1: drive wa=00, wb=10; capture o_result<=i_a; go to DONE.
  - Watchdog: if i_z=0 while o_iter==P_NMAX, abort with o_result=0, o_err=1, go to DONE, driving hold codes.
- DONE:
  - o_valid=1, hold codes driven.
  - On i_ready=1: go to IDLE, o_valid drops next cycle.
  - o_result and o_err stay stable until the next start.
- Latency: start edge t → o_valid high after edge t+N+2. Consists of 1 LOAD, N multiplies, 1 zero check.
- N=0: B loads 0, i_z=1 on first RUN cycle, result 1, o_iter=0.
- i_start while busy or in DONE is ignored; there is no queueing.
- i_ready outside DONE is ignored.
- i_ready in the same cycle DONE is entered has no effect; it must be sampled while o_valid=1.
- Width: o_iter saturates logically via the watchdog and never wraps.

Decomposition:
- Shared package factorial_pkg holds:
  - state encoding constants (ST_IDLE, ST_LOAD, ST_RUN, ST_DONE);
  - WA codes WA_HOLD=01... stated exactly: WA_HOLD=2'b00, WA_MUL=2'b01, WA_INIT=2'b10;
  - WB codes WB_LOAD=2'b00, WB_DEC=2'b01, WB_HOLD=2'b10.
- No sub-module. The FSM, operand latch, iteration counter and result register form one block.
- Top-level integration wires o_wa/o_wb/o_n/i_z/i_a to the datapath instance.

Test Plan:
- Reset mid-RUN (N=5, assert i_rst at iter 2) → o_valid=0, o_busy=0, o_wa=00, o_wb=10 immediately; a new start with N=3 then gives 6.
- Start N=5, i_ready held high → o_wa sequence 10,01×5,00; o_valid at start+7 edges; o_result=120, o_iter=5, o_err=0.
- Start N=0 → o_result=1 after 2 edges, o_iter=0; N=1 → o_result=1, o_iter=1.
- Start N=8 → o_result=40320; start N=9 → o_err=1, o_result=0, o_valid next cycle, no LOAD issued.
- Backpressure: N=4, i_ready=0 for 10 cycles → o_valid and o_result=24 held; i_start pulses during DONE ignored; i_ready=1 → IDLE.
- Datapath fault model forcing i_z=0 → watchdog after 8 multiplies: o_err=1, o_result=0.

Source files
------------

// File: rtl/factorial_pkg.sv
// Shared encodings for the factorial controller: FSM states and the
// datapath accumulator (A) / down-counter (B) write-select codes.
package factorial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [1:0] WA_HOLD = 2'b00;
  localparam logic [1:0] WA_MUL  = 2'b01;
  localparam logic [1:0] WA_INIT = 2'b10;

  localparam logic [1:0] WB_LOAD = 2'b00;
  localparam logic [1:0] WB_DEC  = 2'b01;
  localparam logic [1:0] WB_HOLD = 2'b10;

endpackage

// File: rtl/factorial_ctrl.sv
// Factorial sequencer: steps an external A/B datapath to compute N!, then
// holds the result under a valid/ready handshake. Rejects oversize operands.
//
// state | meaning
// IDLE  | waiting for i_start; datapath held
// LOAD  | A<=1, B<=N
// RUN   | A<=A*B, B<=B-1 until B==0, or watchdog abort
// DONE  | result/err valid until i_ready
module factorial_ctrl
  import factorial_pkg::*;
#(
  parameter int W      = 8,
  parameter int P_NMAX = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_n,
  input  logic           i_ready,
  output logic           o_busy,
  output logic           o_valid,
  output logic [2*W-1:0] o_result,
  output logic           o_err,
  output logic [W-1:0]   o_iter,
  output logic [W-1:0]   o_n,
  output logic [1:0]     o_wa,
  output logic [1:0]     o_wb,
  input  logic           i_z,
  input  logic [2*W-1:0] i_a
);

  localparam logic [W-1:0] NMAX = W'(P_NMAX);

  state_t state, state_nxt;
  logic   accept, reject, mul, capture, abort;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      o_n      <= '0;
      o_iter   <= '0;
      o_result <= '0;
      o_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        o_n      <= i_n;
        o_iter   <= '0;
        o_err    <= 1'b0;
        o_result <= '0;
      end
      if (reject || abort) begin
        o_result <= '0;
        o_err    <= 1'b1;
      end
      if (mul)     o_iter   <= o_iter + 1'b1;
      if (capture) o_result <= i_a;
    end
  end

  always_comb begin
    state_nxt = state;
    o_wa      = WA_HOLD;
    o_wb      = WB_HOLD;
    accept    = 1'b0;
    reject    = 1'b0;
    mul       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_n <= NMAX) begin
            accept    = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            reject    = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        o_wa      = WA_INIT;
        o_wb      = WB_LOAD;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_z) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (o_iter == NMAX) begin
          // B should have reached zero by now; the datapath is stuck
          abort     = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          mul  = 1'b1;
          o_wa = WA_MUL;
          o_wb = WB_DEC;
        end
      end
      ST_DONE: begin
        if (i_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_valid = (state == ST_DONE);
  assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_factorial_ctrl.sv
// Bench for factorial_ctrl: behavioural A/B datapath with a stuck-flag fault
// option, directed cases plus randomized operands and handshake timing.
module tb_factorial_ctrl;

  localparam int W    = 8;
  localparam int NMAX = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   n_in;
  logic           ready;
  logic           busy;
  logic           valid;
  logic [2*W-1:0] result;
  logic           err;
  logic [W-1:0]   iter;
  logic [W-1:0]   n_lat;
  logic [1:0]     wa;
  logic [1:0]     wb;
  logic           z;
  logic [2*W-1:0] dp_a;
  logic [W-1:0]   dp_b;
  logic           fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  factorial_ctrl #(.W(W), .P_NMAX(NMAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_n(n_in), .i_ready(ready),
    .o_busy(busy), .o_valid(valid), .o_result(result), .o_err(err),
    .o_iter(iter), .o_n(n_lat), .o_wa(wa), .o_wb(wb), .i_z(z), .i_a(dp_a)
  );

  // datapath model driven by the select codes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a <= '0;
      dp_b <= '0;
    end else begin
      case (wa)
        2'b01:   dp_a <= 16'(dp_a * {8'd0, dp_b});
        2'b10:   dp_a <= 16'd1;
        default: dp_a <= dp_a;
      endcase
      case (wb)
        2'b00:   dp_b <= n_lat;
        2'b01:   dp_b <= dp_b - 8'd1;
        default: dp_b <= dp_b;
      endcase
    end
  end
  assign z = fault ? 1'b0 : (dp_b == '0);

  function automatic longint fact(input int n);
    longint r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation; rw<0 means i_ready held high throughout, else rw stall cycles in DONE.
  task automatic do_op(input int n, input bit flt, input int rw, input bit noise);
    bit     exp_err;
    int     exp_lat, mults, e;
    longint exp_res;
    logic [2*W-1:0] held;
    exp_err = (n > NMAX) || flt;
    mults   = flt ? NMAX : n;
    exp_lat = (n > NMAX) ? 0 : mults + 2;
    exp_res = exp_err ? 0 : fact(n);
    @(negedge clk);
    check("idle_busy", busy, 0);
    fault = flt;
    ready = (rw < 0);
    start = 1'b1;
    n_in  = W'(n);
    @(negedge clk);
    start = 1'b0;
    e = 0;
    while (!valid && e < 40) begin
      check("wa_seq", wa, (e == 0) ? 2 : (e <= mults) ? 1 : 0);
      check("wb_seq", wb, (e == 0) ? 0 : (e <= mults) ? 1 : 2);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        n_in  = W'($urandom_range(0, 255));
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    check("latency", e, exp_lat);
    check("valid", valid, 1);
    check("busy_done", busy, 1);
    check("result", result, exp_res);
    check("err", err, exp_err);
    check("wa_done", wa, 0);
    check("wb_done", wb, 2);
    if (n <= NMAX) begin
      check("iter", iter, mults);
      check("o_n", n_lat, n);
    end
    if (rw < 0) begin
      @(negedge clk);
      ready = 1'b0;
    end else begin
      held = result;
      for (int i = 0; i < rw; i++) begin
        start = 1'($urandom_range(0, 1));
        n_in  = W'($urandom_range(0, 12));
        @(negedge clk);
        check("bp_valid", valid, 1);
        check("bp_result", result, held);
      end
      start = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
    fault = 1'b0;
    check("valid_drop", valid, 0);
    check("busy_drop", busy, 0);
    check("result_hold", result, exp_res);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; n_in = '0; ready = 1'b0; fault = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_iter", iter, 0);
    check("rst_wa", wa, 0);
    check("rst_wb", wb, 2);
    rst = 1'b0;

    do_op(5, 0, -1, 0);
    do_op(0, 0, 2, 0);
    do_op(1, 0, 0, 0);
    do_op(8, 0, 1, 0);
    do_op(9, 0, 1, 0);
    do_op(4, 0, 10, 0);
    do_op(3, 1, 2, 0);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; n_in = 8'd5;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (iter != 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_iter_reached", iter, 2);
    rst = 1'b1;
    #1;
    check("mid_valid", valid, 0);
    check("mid_busy", busy, 0);
    check("mid_wa", wa, 0);
    check("mid_wb", wb, 2);
    @(negedge clk);
    rst = 1'b0;
    do_op(3, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      do_op($urandom_range(0, 11), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 5)) - 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
